// File: rtl/xeng_vacc_pkg.sv
// Shared definitions for the X-engine vector accumulator: FSM encoding and lane order.
package xeng_vacc_pkg;

    localparam int N_LANES = 8;

    // Lane 0 occupies the most significant slice of din/dout.
    typedef enum int {
        LANE_XX_R = 0,
        LANE_XX_I = 1,
        LANE_YY_R = 2,
        LANE_YY_I = 3,
        LANE_XY_R = 4,
        LANE_XY_I = 5,
        LANE_YX_R = 6,
        LANE_YX_I = 7
    } vacc_lane_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_FIRST = 3'd2,
        ST_ACCUM = 3'd3,
        ST_DUMP  = 3'd4
    } vacc_state_e;

endpackage

// File: rtl/xeng_vacc_lane_add.sv
// One lane of the accumulator datapath: sign-extend the incoming lane and add it
// to the buffered partial sum, registered.
module vacc_lane_add #(
    parameter int LANE_IN  = 15,
    parameter int LANE_OUT = 23
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [LANE_OUT-1:0] acc,
    input  logic [LANE_IN-1:0]  din,
    output logic [LANE_OUT-1:0] sum
);

    logic [LANE_OUT-1:0] sum_d;
    logic [LANE_OUT-1:0] sum_q;

    // Two's complement wrap on overflow; no saturation.
    always_comb begin
        sum_d = sum_q;
        if (en) begin
            sum_d = acc + {{(LANE_OUT-LANE_IN){din[LANE_IN-1]}}, din};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/xeng_vacc.sv
// Long-term vector accumulator behind the X-engine: sums acc_len_m1+1 windows per
// buffer index and streams the result out on the final window, two cycles after input.
module xeng_vacc
    import xeng_vacc_pkg::*;
#(
    parameter int ACC_WIDTH    = 120,
    parameter int VECTOR_LEN   = 544,
    parameter int ACC_LEN_BITS = 8,
    parameter int MCNT_WIDTH   = 48
) (
    input  logic                                                   clk,
    input  logic                                                   rst_n,
    input  logic                                                   sync_in,
    input  logic [ACC_WIDTH-1:0]                                   din,
    input  logic                                                   vld,
    input  logic                                                   window_vld,
    input  logic [MCNT_WIDTH-1:0]                                  mcnt,
    input  logic [ACC_LEN_BITS-1:0]                                acc_len_m1,
    output logic [N_LANES*(ACC_WIDTH/N_LANES+ACC_LEN_BITS)-1:0]    dout,
    output logic                                                   dout_vld,
    output logic                                                   sync_out,
    output logic [MCNT_WIDTH-1:0]                                  mcnt_out,
    output logic                                                   err,
    output logic [2:0]                                             dbg_state
);

    localparam int LANE_IN  = ACC_WIDTH / N_LANES;
    localparam int LANE_OUT = LANE_IN + ACC_LEN_BITS;
    localparam int DOUT_W   = N_LANES * LANE_OUT;
    localparam int IDX_W    = (VECTOR_LEN > 1) ? $clog2(VECTOR_LEN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(VECTOR_LEN - 1);

    vacc_state_e              state_q, state_d, eff_state;
    logic [IDX_W-1:0]         idx_q, idx_d, eff_idx;
    logic [ACC_LEN_BITS-1:0]  win_q, win_d, eff_win;
    logic [ACC_LEN_BITS-1:0]  acc_len_q, acc_len_d, eff_len;
    logic                     err_q, err_d;
    logic [MCNT_WIDTH-1:0]    mcnt_cap_q, mcnt_cap_d;
    logic [MCNT_WIDTH-1:0]    mcnt_out_q, mcnt_out_d;

    logic                     word, use_buf, wr, dump;

    logic                     s1_vld_q, s1_use_buf_q, s1_wr_q, s1_dump_q, s1_sync_q;
    logic                     s1_sync_d;
    logic [IDX_W-1:0]         s1_idx_q;
    logic [ACC_WIDTH-1:0]     s1_din_q;
    logic                     s2_wr_q, s2_dump_q, s2_sync_q;
    logic [IDX_W-1:0]         s2_idx_q;

    logic [DOUT_W-1:0]        mem [VECTOR_LEN];
    logic [DOUT_W-1:0]        rd_data_q;
    logic [IDX_W-1:0]         rd_addr_d;
    logic [DOUT_W-1:0]        acc_op;
    logic [DOUT_W-1:0]        sum_w;

    // sync_in overrides whatever is in flight: the cycle behaves as if ARMED with fresh counters.
    always_comb begin
        eff_state  = sync_in ? ST_ARMED : state_q;
        eff_len    = sync_in ? acc_len_m1 : acc_len_q;
        eff_idx    = sync_in ? '0 : idx_q;
        eff_win    = sync_in ? '0 : win_q;

        state_d    = eff_state;
        idx_d      = eff_idx;
        win_d      = eff_win;
        acc_len_d  = eff_len;
        err_d      = sync_in ? 1'b0 : err_q;
        mcnt_cap_d = mcnt_cap_q;
        use_buf    = 1'b0;
        wr         = 1'b0;
        dump       = 1'b0;
        word       = vld && window_vld && (eff_state != ST_IDLE);

        if ((eff_state != ST_IDLE) && vld && !window_vld) begin
            err_d = 1'b1;
        end

        if (!sync_in && !window_vld && (idx_q != '0)) begin
            err_d   = 1'b1;
            state_d = ST_ARMED;
            idx_d   = '0;
            win_d   = '0;
        end else if (word) begin
            case (eff_state)
                ST_ARMED, ST_FIRST: begin
                    wr   = (eff_len != '0);
                    dump = (eff_len == '0);
                end
                ST_ACCUM: begin
                    wr      = 1'b1;
                    use_buf = 1'b1;
                end
                ST_DUMP: begin
                    dump    = 1'b1;
                    use_buf = (eff_len != '0);
                end
                default: ;
            endcase

            if ((eff_idx == '0) && ((eff_state == ST_ARMED) || (eff_state == ST_FIRST) ||
                                    ((eff_state == ST_DUMP) && (eff_len == '0)))) begin
                mcnt_cap_d = mcnt;
            end

            if (eff_state == ST_ARMED) begin
                state_d = (eff_len == '0) ? ST_DUMP : ST_FIRST;
            end

            if (eff_idx == IDX_LAST) begin
                idx_d = '0;
                case (eff_state)
                    ST_ARMED, ST_FIRST: begin
                        if (eff_len == '0) begin
                            win_d   = '0;
                            state_d = ST_DUMP;
                        end else begin
                            win_d   = 1;
                            state_d = (eff_len == 1) ? ST_DUMP : ST_ACCUM;
                        end
                    end
                    ST_ACCUM: begin
                        win_d   = eff_win + 1'b1;
                        state_d = ((eff_win + 1'b1) == eff_len) ? ST_DUMP : ST_ACCUM;
                    end
                    ST_DUMP: begin
                        win_d   = '0;
                        state_d = (eff_len == '0) ? ST_DUMP : ST_FIRST;
                    end
                    default: ;
                endcase
            end else begin
                idx_d = eff_idx + 1'b1;
            end
        end

        s1_sync_d  = dump && (eff_idx == '0);
        rd_addr_d  = eff_idx;
        // mcnt_out moves only when the first dump word leaves, so it holds for the whole dump.
        mcnt_out_d = s1_sync_q ? mcnt_cap_q : mcnt_out_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            win_q        <= '0;
            acc_len_q    <= '0;
            err_q        <= 1'b0;
            mcnt_cap_q   <= '0;
            mcnt_out_q   <= '0;
            s1_vld_q     <= 1'b0;
            s1_use_buf_q <= 1'b0;
            s1_wr_q      <= 1'b0;
            s1_dump_q    <= 1'b0;
            s1_sync_q    <= 1'b0;
            s1_idx_q     <= '0;
            s1_din_q     <= '0;
            s2_wr_q      <= 1'b0;
            s2_dump_q    <= 1'b0;
            s2_sync_q    <= 1'b0;
            s2_idx_q     <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            win_q        <= win_d;
            acc_len_q    <= acc_len_d;
            err_q        <= err_d;
            mcnt_cap_q   <= mcnt_cap_d;
            mcnt_out_q   <= mcnt_out_d;
            s1_vld_q     <= word && !(!sync_in && !window_vld && (idx_q != '0));
            s1_use_buf_q <= use_buf;
            s1_wr_q      <= wr;
            s1_dump_q    <= dump;
            s1_sync_q    <= s1_sync_d;
            s1_idx_q     <= eff_idx;
            s1_din_q     <= din;
            s2_wr_q      <= s1_wr_q;
            s2_dump_q    <= s1_dump_q;
            s2_sync_q    <= s1_sync_q;
            s2_idx_q     <= s1_idx_q;
        end
    end

    // Simple dual-port buffer; a word's write-back lands two cycles after its read,
    // well before the same index is read again one window later.
    always_ff @(posedge clk) begin
        if (s2_wr_q) begin
            mem[s2_idx_q] <= sum_w;
        end
        rd_data_q <= mem[rd_addr_d];
    end

    assign acc_op = s1_use_buf_q ? rd_data_q : '0;

    for (genvar l = 0; l < N_LANES; l++) begin : g_lane
        localparam int IN_MSB  = ACC_WIDTH - 1 - l * LANE_IN;
        localparam int OUT_MSB = DOUT_W - 1 - l * LANE_OUT;
        vacc_lane_add #(
            .LANE_IN  (LANE_IN),
            .LANE_OUT (LANE_OUT)
        ) u_add (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (s1_vld_q),
            .acc   (acc_op[OUT_MSB -: LANE_OUT]),
            .din   (s1_din_q[IN_MSB -: LANE_IN]),
            .sum   (sum_w[OUT_MSB -: LANE_OUT])
        );
    end

    assign dout      = sum_w;
    assign dout_vld  = s2_dump_q;
    assign sync_out  = s2_sync_q;
    assign mcnt_out  = mcnt_out_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_xeng_vacc.sv
// Directed bench for xeng_vacc with a small vector length; expected dumps come from
// a per-index accumulation model fed by the same directed window values.
module tb_xeng_vacc;
    import xeng_vacc_pkg::*;

    localparam int ACC_WIDTH    = 120;
    localparam int VECTOR_LEN   = 16;
    localparam int ACC_LEN_BITS = 8;
    localparam int MCNT_WIDTH   = 48;
    localparam int LANE_IN      = ACC_WIDTH / 8;
    localparam int LANE_OUT     = LANE_IN + ACC_LEN_BITS;
    localparam int DW           = 8 * LANE_OUT;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    sync_in = 1'b0;
    logic [ACC_WIDTH-1:0]    din = '0;
    logic                    vld = 1'b0;
    logic                    window_vld = 1'b0;
    logic [MCNT_WIDTH-1:0]   mcnt = '0;
    logic [ACC_LEN_BITS-1:0] acc_len_m1 = '0;
    logic [DW-1:0]           dout;
    logic                    dout_vld;
    logic                    sync_out;
    logic [MCNT_WIDTH-1:0]   mcnt_out;
    logic                    err;
    logic [2:0]              dbg_state;

    xeng_vacc #(
        .ACC_WIDTH    (ACC_WIDTH),
        .VECTOR_LEN   (VECTOR_LEN),
        .ACC_LEN_BITS (ACC_LEN_BITS),
        .MCNT_WIDTH   (MCNT_WIDTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sync_in    (sync_in),
        .din        (din),
        .vld        (vld),
        .window_vld (window_vld),
        .mcnt       (mcnt),
        .acc_len_m1 (acc_len_m1),
        .dout       (dout),
        .dout_vld   (dout_vld),
        .sync_out   (sync_out),
        .mcnt_out   (mcnt_out),
        .err        (err),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0]         exp_q[$];
    bit                    exp_sync_q[$];
    logic [MCNT_WIDTH-1:0] exp_mcnt_q[$];
    int                    exp_cyc_q[$];

    int                    acc_m [VECTOR_LEN][8];
    logic [MCNT_WIDTH-1:0] dump_mcnt = '0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] pack_acc(input int j);
        logic [DW-1:0]       w;
        logic [LANE_OUT-1:0] t;
        w = '0;
        for (int l = 0; l < 8; l++) begin
            t = LANE_OUT'(acc_m[j][l]);
            w[DW-1-l*LANE_OUT -: LANE_OUT] = t;
        end
        return w;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (dout_vld) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_dout", dout_vld, 0);
                end else begin
                    check("dout", dout, exp_q.pop_front());
                    check("sync_out", sync_out, exp_sync_q.pop_front());
                    check("mcnt_out", mcnt_out, exp_mcnt_q.pop_front());
                    check("latency", cyc, exp_cyc_q.pop_front());
                end
            end else if (sync_out) begin
                check("sync_no_vld", sync_out, 0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Lane l of word j carries base + ls*l + is*j.
    task automatic send_window(input int base, input int ls, input int is, input int nwords,
                               input bit first, input bit dump, input bit sync_first,
                               input logic [ACC_LEN_BITS-1:0] len, input logic [MCNT_WIDTH-1:0] m);
        int v;
        for (int j = 0; j < nwords; j++) begin
            @(posedge clk); #1;
            sync_in    = sync_first && (j == 0);
            acc_len_m1 = len;
            vld        = 1'b1;
            window_vld = 1'b1;
            mcnt       = m;
            for (int l = 0; l < 8; l++) begin
                v = base + ls * l + is * j;
                din[ACC_WIDTH-1-l*LANE_IN -: LANE_IN] = LANE_IN'(v);
                acc_m[j][l] = first ? v : acc_m[j][l] + v;
            end
            if (first && (j == 0)) dump_mcnt = m;
            if (dump) begin
                exp_q.push_back(pack_acc(j));
                exp_sync_q.push_back(j == 0);
                exp_mcnt_q.push_back(dump_mcnt);
                exp_cyc_q.push_back(cyc + 2);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            vld     = 1'b0;
            sync_in = 1'b0;
        end
    endtask

    task automatic do_sync(input logic [ACC_LEN_BITS-1:0] len);
        @(posedge clk); #1;
        sync_in    = 1'b1;
        acc_len_m1 = len;
        vld        = 1'b0;
        @(posedge clk); #1;
        sync_in    = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dout", dout, 0);
        check("rst_dout_vld", dout_vld, 0);
        check("rst_sync_out", sync_out, 0);
        check("rst_mcnt_out", mcnt_out, 0);
        check("rst_err", err, 0);
        check("rst_state", dbg_state, ST_IDLE);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Traffic before any sync is ignored.
        send_window(3, 1, 1, VECTOR_LEN, 1'b0, 1'b0, 1'b0, 8'd0, 48'h0AA);
        idle(4);
        check("idle_err", err, 0);
        check("idle_state", dbg_state, ST_IDLE);

        // Four windows of +1 -> every lane 4.
        do_sync(8'd3);
        check("sync_state", dbg_state, ST_ARMED);
        for (int k = 0; k < 4; k++)
            send_window(1, 0, 0, VECTOR_LEN, k == 0, k == 3, 1'b0, 8'd3, 48'h100 + 48'(k));
        idle(4);
        check("post_dump_state", dbg_state, ST_FIRST);

        // Single-window dumps of negative lanes, back to back.
        do_sync(8'd0);
        send_window(-5, 0, 0, VECTOR_LEN, 1'b1, 1'b1, 1'b0, 8'd0, 48'h200);
        send_window(-5, -1, 2, VECTOR_LEN, 1'b1, 1'b1, 1'b0, 8'd0, 48'h201);
        idle(4);
        check("len0_state", dbg_state, ST_DUMP);

        // Full-length accumulation of the largest positive lane value.
        do_sync(8'd255);
        for (int k = 0; k < 256; k++)
            send_window(16383, 0, 0, VECTOR_LEN, k == 0, k == 255, 1'b0, 8'd255, 48'h300 + 48'(k));
        idle(4);

        // window_vld drops mid-window.
        do_sync(8'd3);
        send_window(7, 1, 0, 10, 1'b1, 1'b0, 1'b0, 8'd3, 48'h400);
        @(posedge clk); #1;
        vld        = 1'b0;
        window_vld = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("short_window_err", err, 1);
        check("short_window_state", dbg_state, ST_ARMED);
        do_sync(8'd3);
        check("sync_clears_err", err, 0);
        @(posedge clk); #1;
        vld = 1'b1;
        @(posedge clk); #1;
        vld = 1'b0;
        @(posedge clk); #1;
        check("vld_outside_window_err", err, 1);
        check("vld_outside_window_state", dbg_state, ST_ARMED);

        // Abort in window 2 via a sync that also carries the first word of the new set.
        do_sync(8'd3);
        check("err_cleared_again", err, 0);
        send_window(2, 3, 1, VECTOR_LEN, 1'b1, 1'b0, 1'b0, 8'd3, 48'h600);
        send_window(2, 3, 1, VECTOR_LEN, 1'b0, 1'b0, 1'b0, 8'd3, 48'h601);
        send_window(2, 3, 1, 7, 1'b0, 1'b0, 1'b0, 8'd3, 48'h602);
        for (int k = 0; k < 4; k++)
            send_window(5, -2, 3, VECTOR_LEN, k == 0, k == 3, k == 0, 8'd3, 48'h700 + 48'(k));
        idle(4);
        check("abort_err", err, 0);

        // Continuous pairs: windows 1+2 and 3+4.
        do_sync(8'd1);
        for (int k = 1; k <= 4; k++)
            send_window(k, 10, 100, VECTOR_LEN, (k % 2) == 1, (k % 2) == 0, 1'b0, 8'd1, 48'h500 + 48'(k));
        idle(6);

        check("exp_q_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
